// File: rtl/mux_e_somador_pkg.sv
// Shared constants for the mux-and-add stage: default operand width and
// the select encodings for the 2:1 operand multiplexer.
package mux_e_somador_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

endpackage : mux_e_somador_pkg

// File: rtl/mux_e_somador_if.sv
// Operand/result bundle for mux_e_somador. The master drives operands and
// observes results; the slave is the datapath stage itself.
interface mux_e_somador_if #(
  parameter int WIDTH = mux_e_somador_pkg::DEF_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             sel;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c, sel,
    input  res, carry, out_valid
  );

  modport slave (
    input  in_valid, a, b, c, sel,
    output res, carry, out_valid
  );

endinterface : mux_e_somador_if

// File: rtl/mux_e_somador_mux2.sv
// Combinational 2:1 operand selector; the unselected input never reaches
// the output, so unknowns on it cannot leak downstream.
module mux_e_somador_mux2
  import mux_e_somador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = in0_i;
    if (sel_i == SEL_C) begin
      out_o = in1_i;
    end
  end

endmodule : mux_e_somador_mux2

// File: rtl/mux_e_somador.sv
// Registered res = a + (sel ? c : b) with carry-out; 1-cycle latency,
// back-to-back throughput, no backpressure. res/carry hold when idle.
module mux_e_somador
  import mux_e_somador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  mux_e_somador_if.slave    bus
);

  logic [WIDTH-1:0] op;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             out_valid_q;

  mux_e_somador_mux2 #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .in0_i (bus.b),
    .in1_i (bus.c),
    .sel_i (bus.sel),
    .out_o (op)
  );

  // Extra MSB of the zero-extended sum is the carry-out.
  assign sum_d = {1'b0, bus.a} + {1'b0, op};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q   <= sum_d[WIDTH-1:0];
        carry_q <= sum_d[WIDTH];
      end
    end
  end

  assign bus.res       = res_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;

endmodule : mux_e_somador

// File: tb/tb_mux_e_somador.sv
// Randomized scoreboard bench for mux_e_somador: the driver pushes expected
// results from an arithmetic model, a negedge monitor pops and compares.
module tb_mux_e_somador;
  import mux_e_somador_pkg::*;

  localparam int W = DEF_WIDTH;

  typedef struct {
    int res;
    int carry;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_e_somador_if #(.WIDTH(W)) bus ();

  mux_e_somador #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   hold_res = 0;
  int   hold_carry = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Reference: plain integer addition, wrap modulo 2^W, carry = overflow.
  function automatic void model(int a, int b, int c, bit s, output int r, output int cy);
    int op;
    int sum;
    op  = (s == SEL_C) ? c : b;
    sum = a + op;
    r   = sum % (1 << W);
    cy  = (sum >= (1 << W)) ? 1 : 0;
  endfunction

  task automatic drive(bit v, int a, int b, int c, bit s);
    exp_t x;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a        = W'(a);
    bus.b        = W'(b);
    bus.c        = W'(c);
    bus.sel      = s;
    if (v) begin
      model(a, b, c, s, x.res, x.carry);
      x.cyc = cyc + 1;
      sbq.push_back(x);
    end
  endtask

  // Monitor: every negedge either a valid result is popped and compared,
  // or the held result is checked against the last expected value.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_res", int'(bus.res), 0);
      check("rst_carry", int'(bus.carry), 0);
      hold_res   = 0;
      hold_carry = 0;
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("res", int'(bus.res), e.res);
        check("carry", int'(bus.carry), e.carry);
        hold_res   = e.res;
        hold_carry = e.carry;
      end
    end else begin
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        check("missing_valid", 0, 1);
        void'(sbq.pop_front());
      end
      check("hold_res", int'(bus.res), hold_res);
      check("hold_carry", int'(bus.carry), hold_carry);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;
    bus.sel      = SEL_B;
    #1;
    check("init_res", int'(bus.res), 0);
    check("init_carry", int'(bus.carry), 0);
    check("init_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed operand patterns, overflow corners and hold.
    drive(1, 3, 5, 9, SEL_C);
    drive(1, 3, 4, 9, SEL_B);
    drive(1, 15, 0, 1, SEL_C);
    drive(1, 8, 8, 0, SEL_B);
    drive(1, 7, 8, 0, SEL_B);
    repeat (3) drive(0, 1, 1, 1, SEL_B);
    // Only the unselected operand differs between these two.
    drive(1, 5, 2, 11, SEL_C);
    drive(1, 5, 13, 11, SEL_C);
    drive(1, 6, 9, 0, SEL_B);
    drive(1, 6, 9, 15, SEL_B);
    drive(0, 0, 0, 0, SEL_B);

    // Streaming with alternating select.
    drive(1, 1, 2, 3, SEL_B);
    drive(1, 4, 5, 6, SEL_C);
    drive(1, 7, 8, 9, SEL_B);
    drive(1, 10, 11, 12, SEL_C);
    drive(0, 0, 0, 0, SEL_B);

    // Asynchronous reset mid-cycle with nonzero outputs and an input in flight.
    drive(1, 9, 9, 9, SEL_B);
    drive(1, 1, 2, 3, SEL_B);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    check("async_rst_res", int'(bus.res), 0);
    check("async_rst_carry", int'(bus.carry), 0);
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1, 14, 3, 2, SEL_C);

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    drive(0, 0, 0, 0, SEL_B);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mux_e_somador

// File: doc/mux_e_somador.md
Name: mux_e_somador

Overview:
- Registered 2:1 operand multiplexer followed by an adder: res = a + (sel ? c : b).
- Small arithmetic datapath stage for lab/ALU sprint designs.
- One clock domain.
- Output registered with 1-cycle latency, plus a valid flag and a carry-out.

Parameters:
- WIDTH, 4, bit width of a, b, c and res.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a/b/c/sel in the current cycle.
- a  input  WIDTH  first addend, always used.
- b  input  WIDTH  mux input 0, selected when sel=0.
- c  input  WIDTH  mux input 1, selected when sel=1.
- sel  input  1  operand select: 0 selects b, 1 selects c.
- res  output  WIDTH  registered sum a + selected operand, modulo 2^WIDTH.
- carry  output  1  registered carry-out (bit WIDTH) of the addition.
- out_valid  output  1  high for one cycle per accepted input; res and carry are meaningful when high.

Behaviour:
- Reset:
  - While rst=1, res=0, carry=0 and out_valid=0, immediately and independent of clk.
  - Release of rst takes effect at the next rising clk edge.
- Combinational path:
  - op = sel ? c : b.
  - sum = zero-extend(a) + zero-extend(op), WIDTH+1 bits wide.
- On each rising clk edge with rst=0:
  - If in_valid=1: res <= sum[WIDTH-1:0], carry <= sum[WIDTH], out_valid <= 1.
  - If in_valid=0: res and carry hold their previous values, out_valid <= 0.
- Latency is exactly 1 cycle. Back-to-back inputs give back-to-back outputs. There is no backpressure and no stall.
- Arithmetic is unsigned. Wrap-around modulo 2^WIDTH; overflow is reported only through carry. Example: 15+1 gives res=0, carry=1.
- sel, b and c are sampled in the same cycle as a. The unselected operand has no effect on res or carry.
- If rst is asserted mid-stream, any in-flight result is discarded and out_valid drops immediately. The first input after reset release is processed normally.
- X/unknown on the unselected operand must not propagate to res.

Decomposition:
- Shared package mux_e_somador_pkg:
  - WIDTH default constant.
  - SEL_B = 1'b0 and SEL_C = 1'b1 constants.
- Optional combinational sub-module mux2 (parameterised WIDTH, 2:1 selector). The adder and output register stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with outputs nonzero -> res=0, carry=0, out_valid=0 immediately, without waiting for a clock edge.
- a=3, b=5, c=9, sel=1, in_valid=1 -> next cycle res=0xC, carry=0, out_valid=1.
- a=3, b=4, c=9, sel=0, in_valid=1 -> next cycle res=0x7, carry=0, out_valid=1.
- Overflow: a=0xF, c=0x1, sel=1 -> res=0x0, carry=1. Then a=0x8, b=0x8, sel=0 -> res=0x0, carry=1. Then a=0x7, b=0x8, sel=0 -> res=0xF, carry=0.
- Hold: in_valid=0 for 3 cycles after a valid result -> out_valid=0 and res/carry unchanged. Changing the unselected operand during a valid cycle does not change res.
- Streaming: 4 consecutive valid inputs with alternating sel -> 4 consecutive out_valid pulses, each 1 cycle after its input, with matching sums.
